fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 128 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side controller of an asynchronous FIFO
//
// Synchronizes the write-domain Gray pointer into rclk, keeps the read
// pointer (binary and Gray), generates the memory read address and fetches
// words into a one-deep registered output stage with a valid/ready handshake.
//
// Ports:
//   rclk       read-domain clock
//   rrst_n     asynchronous active-low reset
//   wq_wptr    Gray write pointer from the write domain (synchronized here)
//   rptr       Gray read pointer, registered, to the write domain
//   raddr      binary read address to the FIFO memory
//   mem_rdata  combinational memory read data at raddr
//   rdata      registered output word
//   rvalid     rdata holds a valid word
//   rready     consumer accepts rdata this cycle
//   rempty     memory holds no unread word (output register excluded)
//   rcount     words in memory not yet fetched
//   raempty    almost-empty flag, only when FIFO_RD_AEMPTY_EN is defined
//
// Build option: FIFO_RD_AEMPTY_EN adds the raempty port and its logic.

module fifo_rd_ctrl #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 9,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wq_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic                rempty,
`ifdef FIFO_RD_AEMPTY_EN
    output logic [ADDRSIZE:0]   rcount,
    output logic                raempty
`else
    output logic [ADDRSIZE:0]   rcount
`endif
);

    logic [ADDRSIZE:0] rq1_wptr;
    logic [ADDRSIZE:0] rq2_wptr;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin_sync;
    logic [ADDRSIZE:0] rcount_next;
    logic              fetch;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it,
    // which equals the XOR of every right-shifted copy of the code.
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b = g;
        for (int i = 1; i <= ADDRSIZE; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // A word moves from memory into the output stage whenever memory is not
    // empty and the output stage is free or being drained this cycle.
    assign fetch       = !rempty && (!rvalid || rready);
    assign rbin_next   = rbin + {{ADDRSIZE{1'b0}}, fetch};
    assign rgraynext   = (rbin_next >> 1) ^ rbin_next;
    assign wbin_sync   = gray2bin(rq2_wptr);
    // Modulo subtraction keeps the count correct across the MSB wrap.
    assign rcount_next = wbin_sync - rbin_next;
    assign raddr       = rbin[ADDRSIZE-1:0];

    // Two-flop synchronizer for the write pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq1_wptr <= '0;
            rq2_wptr <= '0;
        end else begin
            rq1_wptr <= wq_wptr;
            rq2_wptr <= rq1_wptr;
        end
    end

    // Read pointer and status flags.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rcount <= '0;
        end else begin
            rbin   <= rbin_next;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2_wptr);
            rcount <= rcount_next;
        end
    end

    // Output register: load on fetch, drop valid when drained with nothing
    // behind it, otherwise hold.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (fetch) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

`ifdef FIFO_RD_AEMPTY_EN
    localparam logic [ADDRSIZE:0] AEMPTY_LVL = (ADDRSIZE+1)'(AEMPTY_THRESH);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            raempty <= 1'b1;
        end else begin
            raempty <= (rcount_next <= AEMPTY_LVL);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic [AW:0]   wq_wptr;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          rempty;
    logic [AW:0]   rcount;
`ifdef FIFO_RD_AEMPTY_EN
    logic          raempty;
`endif

    logic [DW-1:0] mem [DEPTH];
    assign mem_rdata = mem[raddr];

    fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .AEMPTY_THRESH(4)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .wq_wptr(wq_wptr), .rptr(rptr),
        .raddr(raddr), .mem_rdata(mem_rdata), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .rempty(rempty),
`ifdef FIFO_RD_AEMPTY_EN
        .rcount(rcount), .raempty(raempty)
`else
        .rcount(rcount)
`endif
    );

    always #5 rclk = ~rclk;

    int n_tests = 0;
    int n_fail  = 0;
    // Reference model: words written and accepted since reset, expected order.
    int wcnt;
    int acc;
    logic [DW-1:0] exp_q [$];

    function automatic logic [AW:0] gray_of(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return (v >> 1) ^ v;
    endfunction

    task automatic step();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wcnt % DEPTH] = d;
        exp_q.push_back(d);
        wcnt++;
        wq_wptr = gray_of(wcnt);
    endtask

    task automatic model_reset();
        wcnt = 0;
        acc = 0;
        exp_q.delete();
        wq_wptr = '0;
        rready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        #2 rrst_n = 1'b0;
        model_reset();
        @(negedge rclk);
        step();
        rrst_n = 1'b1;
    endtask

    // Streams n_new fresh words (pushed at random cycles, memory never
    // overfilled) plus whatever is already outstanding. mode 0: rready held
    // high, 1: toggled every cycle, 2: random.
    task automatic run_stream(input int n_new, input int mode, output int stalls, output int maxcnt);
        int pushed = 0;
        int budget = 0;
        int target;
        int start_acc;
        logic [DW-1:0] x;
        stalls = 0;
        maxcnt = 0;
        target = wcnt + n_new;
        start_acc = acc;
        while (acc < target && budget < 3000) begin
            budget++;
            // Words fetched = words accepted + the one held in the output stage.
            n_tests++;
            if (rptr !== gray_of(acc + int'(rvalid))) begin
                n_fail++;
                $display("FAIL stream_rptr: got %0h expected %0h", rptr, gray_of(acc + int'(rvalid)));
            end
            if (int'(rcount) > maxcnt) maxcnt = int'(rcount);
            case (mode)
                0: rready = 1'b1;
                1: rready = ~rready;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rvalid && rready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got %0h expected no word", rdata);
                end else begin
                    x = exp_q.pop_front();
                    if (rdata !== x) begin
                        n_fail++;
                        $display("FAIL stream_data: got %0h expected %0h", rdata, x);
                    end
                end
                acc++;
            end else if (acc > start_acc) begin
                stalls++;
            end
            if (pushed < n_new && (wcnt - acc) < DEPTH && $urandom_range(0, 1) == 1) begin
                push(8'($urandom));
                pushed++;
            end
            step();
        end
        n_tests++;
        if (acc < target) begin
            n_fail++;
            $display("FAIL stream_timeout: got %0d words expected %0d", acc, target);
        end
    endtask

    task automatic post_idle();
        rready = 1'b0;
        repeat (4) step();
        n_tests++;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %0b expected 0", rvalid); end
        n_tests++;
        if (rempty !== 1'b1) begin n_fail++; $display("FAIL idle_rempty: got %0b expected 1", rempty); end
        n_tests++;
        if (rcount !== '0) begin n_fail++; $display("FAIL idle_rcount: got %0d expected 0", rcount); end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %0b expected 1", rempty); end
            n_tests++;
            if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b expected 0", rvalid); end
            n_tests++;
            if (rcount !== '0) begin n_fail++; $display("FAIL reset_rcount: got %0d expected 0", rcount); end
            n_tests++;
            if (raddr !== '0) begin n_fail++; $display("FAIL reset_raddr: got %0d expected 0", raddr); end
            n_tests++;
            if (rptr !== '0) begin n_fail++; $display("FAIL reset_rptr: got %0h expected 0", rptr); end
            n_tests++;
            if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %0h expected 0", rdata); end
`ifdef FIFO_RD_AEMPTY_EN
            n_tests++;
            if (raempty !== 1'b1) begin n_fail++; $display("FAIL reset_raempty: got %0b expected 1", raempty); end
`endif
            repeat (10) step();
        end
    endtask

    task automatic test_latency();
        logic [DW-1:0] d;
        logic [DW-1:0] x;
        d = 8'($urandom);
        rready = 1'b0;
        push(d);
        // The next rising edge is the first to sample the new pointer.
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (rvalid !== 1'b0) begin n_fail++; $display("FAIL latency_early_%0d: got %0b expected 0", k, rvalid); end
        end
        step();
        n_tests++;
        if (rvalid !== 1'b1) begin n_fail++; $display("FAIL latency_rvalid: got %0b expected 1", rvalid); end
        n_tests++;
        if (rdata !== d) begin n_fail++; $display("FAIL latency_rdata: got %0h expected %0h", rdata, d); end
        n_tests++;
        if (rempty !== 1'b1) begin n_fail++; $display("FAIL latency_rempty: got %0b expected 1", rempty); end
        n_tests++;
        if (rptr !== 5'd1) begin n_fail++; $display("FAIL latency_rptr: got %0h expected 1", rptr); end
        repeat (5) step();
        n_tests++;
        if (rvalid !== 1'b1 || rdata !== d) begin
            n_fail++;
            $display("FAIL hold: got valid=%0b data=%0h expected valid=1 data=%0h", rvalid, rdata, d);
        end
        n_tests++;
        if (rcount !== '0) begin n_fail++; $display("FAIL hold_rcount: got %0d expected 0", rcount); end
        rready = 1'b1;
        x = exp_q.pop_front();
        acc++;
        step();
        rready = 1'b0;
        n_tests++;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL drain_rvalid: got %0b expected 0", rvalid); end
        n_tests++;
        if (x !== d) begin n_fail++; $display("FAIL latency_model: got %0h expected %0h", x, d); end
    endtask

    task automatic test_full_burst();
        int stalls;
        int maxc;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        run_stream(0, 0, stalls, maxc);
        n_tests++;
        if (stalls != 0) begin n_fail++; $display("FAIL burst_stalls: got %0d expected 0", stalls); end
        n_tests++;
        if (maxc != DEPTH) begin n_fail++; $display("FAIL burst_maxcount: got %0d expected %0d", maxc, DEPTH); end
        post_idle();
    endtask

    task automatic test_toggle();
        int stalls;
        int maxc;
        run_stream(8, 1, stalls, maxc);
        post_idle();
    endtask

    task automatic test_wrap();
        int stalls;
        int maxc;
        do_reset();
        run_stream(40, 2, stalls, maxc);
        post_idle();
        n_tests++;
        if (rptr !== 5'd12) begin n_fail++; $display("FAIL wrap_rptr: got %0h expected c", rptr); end
    endtask

    task automatic test_aempty();
        int stalls;
        int maxc;
        logic [DW-1:0] x;
        do_reset();
        for (int i = 0; i < 6; i++) push(8'($urandom));
        rready = 1'b0;
        repeat (6) step();
        n_tests++;
        if (rvalid !== 1'b1) begin n_fail++; $display("FAIL ae_rvalid: got %0b expected 1", rvalid); end
        n_tests++;
        if (rcount !== 5'd5) begin n_fail++; $display("FAIL ae_rcount5: got %0d expected 5", rcount); end
`ifdef FIFO_RD_AEMPTY_EN
        n_tests++;
        if (raempty !== 1'b0) begin n_fail++; $display("FAIL ae_flag_low: got %0b expected 0", raempty); end
`endif
        rready = 1'b1;
        x = exp_q.pop_front();
        acc++;
        n_tests++;
        if (rdata !== x) begin n_fail++; $display("FAIL ae_data: got %0h expected %0h", rdata, x); end
        step();
        rready = 1'b0;
        n_tests++;
        if (rcount !== 5'd4) begin n_fail++; $display("FAIL ae_rcount4: got %0d expected 4", rcount); end
`ifdef FIFO_RD_AEMPTY_EN
        n_tests++;
        if (raempty !== 1'b1) begin n_fail++; $display("FAIL ae_flag_high: got %0b expected 1", raempty); end
`endif
        run_stream(0, 2, stalls, maxc);
        post_idle();
    endtask

    task automatic test_reset_mid();
        int stalls;
        int maxc;
        logic [DW-1:0] d;
        for (int i = 0; i < 6; i++) push(8'($urandom));
        rready = 1'b1;
        repeat (6) step();
        #2 rrst_n = 1'b0;
        #1;
        n_tests++;
        if (rvalid !== 1'b0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got valid=%0b data=%0h expected 0 0", rvalid, rdata);
        end
        n_tests++;
        if (rempty !== 1'b1 || rcount !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got empty=%0b count=%0d expected 1 0", rempty, rcount);
        end
        n_tests++;
        if (rptr !== '0 || raddr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_ptr: got rptr=%0h raddr=%0h expected 0 0", rptr, raddr);
        end
        model_reset();
        @(negedge rclk);
        step();
        rrst_n = 1'b1;
        d = ~mem[0];
        push(d);
        n_tests++;
        if (raddr !== '0) begin n_fail++; $display("FAIL mid_reset_raddr: got %0h expected 0", raddr); end
        run_stream(0, 0, stalls, maxc);
        post_idle();
        n_tests++;
        if (rptr !== 5'd1) begin n_fail++; $display("FAIL mid_reset_rptr: got %0h expected 1", rptr); end
    endtask

    initial begin
        rrst_n = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_latency();
        test_full_burst();
        test_toggle();
        test_wrap();
        test_aempty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
